fp_cmp_arbiter: RTL
===================

FP_CMP_ARBITER -- requirements
Module: fp_cmp_arbiter

Interface
REQ-001 The block SHALL have parameter FIXED_PRIO, default 0; 0 selects round-robin arbitration and 1 gives requester 0 strict priority.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  synchronous, active-low reset, sampled on rising clk.
REQ-004 req0_valid / req1_valid  input  1  requester N presents a compare.
REQ-005 req0_ready / req1_ready  output  1  requester N's compare is accepted this cycle.
REQ-006 req0_a, req0_b, req1_a, req1_b  input  32  IEEE-754 single operands.
REQ-007 req0_op / req1_op  input  2  compare select: 00 LTE, 01 LT, 10 EQ, 11 treated as LTE.
REQ-008 cmp_a, cmp_b  output  32  operands driven to the shared comparator.
REQ-009 cmp_op  output  2  op driven to the shared comparator.
REQ-010 cmp_result  input  32  combinational comparator result, valid in the same cycle as cmp_a/cmp_b/cmp_op.
REQ-011 resp_valid  output  1  response buffer holds a result.
REQ-012 resp_ready  input  1  consumer takes the response.
REQ-013 resp_id  output  1  requester that owns the response.
REQ-014 resp_result  output  32  registered compare result; bit 0 is the flag and bits 31:1 are zero.
REQ-015 resp_nv  output  1  invalid-operand flag; exists only with FP_CMP_ARB_NAN_EN.

Function
REQ-016 A handshake SHALL complete on a requester port when reqN_valid and reqN_ready are both high at a rising edge.
REQ-017 Requesters SHALL hold operands and op stable while valid is high and ready is low; the block SHALL NOT require ready before valid.
REQ-018 can_accept = !resp_valid | resp_ready; at most one ready SHALL be high per cycle, and only when can_accept is high.
REQ-019 With one requester valid and can_accept high, that requester SHALL be granted.
REQ-020 With both valid and FIXED_PRIO=0, the block SHALL grant the requester that is not last_grant; last_grant updates only on a completed grant.
REQ-021 With both valid and FIXED_PRIO=1, the block SHALL grant requester 0.
REQ-022 cmp_a, cmp_b and cmp_op SHALL carry the granted requester's inputs; with no grant they SHALL carry requester last_grant's inputs.
REQ-023 On grant at edge N, the block SHALL capture resp_result and resp_id and set resp_valid at N (latency 1 cycle, visible after edge N).
REQ-024 When resp_valid and resp_ready are both high and no new grant occurs, resp_valid SHALL clear at that edge.
REQ-025 Simultaneous consume and grant SHALL overwrite the buffer with the new result, keep resp_valid high, and give full throughput of 1 per cycle.
REQ-026 When resp_valid is high and resp_ready is low, both ready outputs SHALL be low and resp_* SHALL hold stable.
REQ-027 A requester SHALL never wait more than one grant while the other requester is served, when FIXED_PRIO=0.

Reset
REQ-028 With rst_n low at an edge: resp_valid=0, resp_id=0, resp_result=0, last_grant=1 (so requester 0 wins the first tie), resp_nv=0.
REQ-029 req0_ready and req1_ready SHALL be low while rst_n is low.
REQ-030 A buffered, unconsumed response SHALL be discarded by reset, and no handshake SHALL complete in a reset cycle.

Configuration
REQ-031 Macro FP_CMP_ARB_NAN_EN: when defined, the block SHALL detect NaN operands (exponent 0xFF, mantissa nonzero) on the granted inputs.
REQ-032 With the macro defined and a NaN present, resp_result SHALL be 0 regardless of cmp_result.
REQ-033 With the macro defined, resp_nv SHALL be 1 for any NaN on LT/LTE and for a signalling NaN (mantissa bit 22 = 0) on EQ; it is registered alongside resp_result.
REQ-034 Without the macro, resp_nv SHALL be absent and cmp_result SHALL pass through unmodified.

Verification
REQ-035 Reset then req0 only, a=0x3F800000, b=0x40000000, op=01, cmp_result=1 -> resp_valid=1, resp_id=0, resp_result=1 one cycle later.
REQ-036 Both valid for 4 cycles, resp_ready=1, FIXED_PRIO=0 -> grants 0,1,0,1 and resp_id sequence 0,1,0,1.
REQ-037 resp_valid=1, resp_ready=0 for 3 cycles, both requesting -> both ready low and resp_result stable; resp_ready=1 -> next grant completes the same cycle.
REQ-038 rst_n asserted with resp_valid=1 -> resp_valid=0 next edge and the result is never delivered.
REQ-039 With FP_CMP_ARB_NAN_EN, a=0x7FC00000, op=00, cmp_result=1 -> resp_result=0, resp_nv=1; op=10 with the same inputs -> resp_nv=0.
REQ-040 FIXED_PRIO=1, both valid for 3 cycles -> req0 granted every cycle and req1_ready stays 0.

Source files
------------

// File: rtl/fp_cmp_arbiter.sv
// fp_cmp_arbiter
// ---------------------------------------------------------------------------
// Shares one external single-precision comparator between two requesters.
// Each cycle it grants at most one requester, steers that requester's
// operands and op to the comparator, and captures the comparator's
// combinational answer into a one-entry response buffer. A new grant is
// allowed when the buffer is empty or is being consumed in the same cycle.
// This gives a throughput of one compare per cycle.
//
// Parameters
//   FIXED_PRIO   0: round-robin on ties, 1: requester 0 always wins ties
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   reqN_valid / reqN_ready    requester N handshake (N = 0, 1)
//   reqN_a, reqN_b, reqN_op    requester N operands and compare select
//                              (00 LTE, 01 LT, 10 EQ, 11 LTE)
//   cmp_a, cmp_b, cmp_op       operands and op driven to the comparator
//   cmp_result                 comparator answer, same cycle (bit 0 used)
//   resp_valid / resp_ready    response buffer handshake
//   resp_id                    requester owning the buffered response
//   resp_result                buffered flag in bit 0, bits 31:1 zero
//   resp_nv                    invalid-operand flag (FP_CMP_ARB_NAN_EN only)
//
// Build option
//   FP_CMP_ARB_NAN_EN  When defined, NaN operands force resp_result to 0.
//                      resp_nv then reports invalid operands. NaN on LT/LTE
//                      always counts as invalid. On EQ only a signalling
//                      NaN counts as invalid.
// ---------------------------------------------------------------------------
module fp_cmp_arbiter #(
    parameter int FIXED_PRIO = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_a,
    input  logic [31:0] req0_b,
    input  logic [1:0]  req0_op,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_a,
    input  logic [31:0] req1_b,
    input  logic [1:0]  req1_op,
    output logic [31:0] cmp_a,
    output logic [31:0] cmp_b,
    output logic [1:0]  cmp_op,
    input  logic [31:0] cmp_result,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic        resp_id,
`ifdef FP_CMP_ARB_NAN_EN
    output logic        resp_nv,
`endif
    output logic [31:0] resp_result
);

    localparam logic PRIO0 = (FIXED_PRIO != 0);
    localparam logic [1:0] OP_EQ = 2'b10;

    logic        resp_valid_q;
    logic        resp_id_q;
    logic [31:0] resp_result_q;
    logic [31:0] resp_result_d;
    logic        last_grant_q;
    logic        can_accept;
    logic        gnt0;
    logic        gnt1;
    logic        any_gnt;
    logic        sel;

    // Only bit 0 of the comparator answer carries information.
    logic        unused_cmp_bits;
    assign unused_cmp_bits = ^cmp_result[31:1];

    assign can_accept = !resp_valid_q || resp_ready;

    // On a tie, round-robin favours the requester that did not win last.
    // Reset leaves last_grant at 1, so requester 0 wins the first tie.
    assign gnt0 = rst_n && can_accept && req0_valid &&
                  (!req1_valid || PRIO0 || last_grant_q);
    assign gnt1 = rst_n && can_accept && req1_valid &&
                  (!req0_valid || (!PRIO0 && !last_grant_q));
    assign any_gnt = gnt0 || gnt1;

    // With no grant the comparator keeps looking at the last winner's inputs.
    assign sel = gnt1 || (!gnt0 && last_grant_q);

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign cmp_a      = sel ? req1_a  : req0_a;
    assign cmp_b      = sel ? req1_b  : req0_b;
    assign cmp_op     = sel ? req1_op : req0_op;

`ifdef FP_CMP_ARB_NAN_EN
    logic [31:0] opnd [2];
    logic [1:0]  is_nan;
    logic [1:0]  is_snan;
    logic        resp_nv_q;
    logic        resp_nv_d;

    assign opnd[0] = cmp_a;
    assign opnd[1] = cmp_b;

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_nan
            assign is_nan[gi]  = (opnd[gi][30:23] == 8'hFF) &&
                                 (opnd[gi][22:0] != 23'd0);
            // Quiet NaNs have mantissa bit 22 set.
            assign is_snan[gi] = is_nan[gi] && !opnd[gi][22];
        end
    endgenerate

    always_comb begin
        resp_result_d = {31'd0, cmp_result[0]};
        resp_nv_d     = 1'b0;
        if (|is_nan) begin
            resp_result_d = 32'd0;
            resp_nv_d     = (cmp_op == OP_EQ) ? (|is_snan) : 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_nv_q <= 1'b0;
        end else if (any_gnt) begin
            resp_nv_q <= resp_nv_d;
        end
    end

    assign resp_nv = resp_nv_q;
`else
    always_comb begin
        resp_result_d = {31'd0, cmp_result[0]};
    end
`endif

    // A grant overwrites the buffer even while it is being consumed.
    // This is what allows back-to-back compares every cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            resp_valid_q  <= 1'b0;
            resp_id_q     <= 1'b0;
            resp_result_q <= 32'd0;
            last_grant_q  <= 1'b1;
        end else if (any_gnt) begin
            resp_valid_q  <= 1'b1;
            resp_id_q     <= sel;
            resp_result_q <= resp_result_d;
            last_grant_q  <= sel;
        end else if (resp_ready) begin
            resp_valid_q  <= 1'b0;
        end
    end

    assign resp_valid  = resp_valid_q;
    assign resp_id     = resp_id_q;
    assign resp_result = resp_result_q;

endmodule
